// File: rtl/mul_div_pkg.sv
// Shared widths, state encoding and saturation constants for the multiplier/divider datapath.
package mul_div_pkg;
    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;
    localparam int ITER       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [DIVISOR_W-1:0] Q_OVF = 16'h8000;
    localparam logic [DIVISOR_W-1:0] Q_DZ  = 16'hFFFF;

    // Magnitudes are unsigned, so the most negative input maps to 2^(W-1) exactly.
    function automatic logic [DIVIDEND_W-1:0] abs32(input logic [DIVIDEND_W-1:0] v);
        return v[DIVIDEND_W-1] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [DIVISOR_W-1:0] abs16(input logic [DIVISOR_W-1:0] v);
        return v[DIVISOR_W-1] ? (~v + 16'd1) : v;
    endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
module div_step
    import mul_div_pkg::*;
(
    input  logic [DIVISOR_W-1:0] i_rem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_div,
    output logic [DIVISOR_W-1:0] o_rem,
    output logic                 o_qbit
);
    logic [DIVISOR_W:0] w_part;
    logic [DIVISOR_W:0] w_diff;

    assign w_part = {i_rem, i_bit};
    assign w_diff = w_part - {1'b0, i_div};
    assign o_qbit = (w_part >= {1'b0, i_div});
    // With rem < div on entry, the kept value always fits back into DIVISOR_W bits.
    assign o_rem  = DIVISOR_W'(o_qbit ? w_diff : w_part);
endmodule

// File: rtl/div32by16_signed.sv
// Sequential signed 32/16 divider: 16 restoring iterations on magnitudes, then one sign-fix cycle.
module div32by16_signed
    import mul_div_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  dz,
    output logic                  ovf
);
    div_state_t r_state, w_next;

    logic [4:0]            r_cnt;
    logic [DIVISOR_W-1:0]  r_rem, r_nlo, r_q, r_dabs, r_nraw_lo;
    logic                  r_sign_q, r_sign_r, r_dz_p, r_uovf;
    logic [DIVISOR_W-1:0]  r_quot, r_rmdr;
    logic                  r_dz, r_ovf;

    logic [DIVIDEND_W-1:0] w_nabs;
    logic [DIVISOR_W-1:0]  w_dabs;
    logic [DIVISOR_W-1:0]  w_step_rem;
    logic                  w_qbit;
    logic                  w_s_ovf;
    logic [DIVISOR_W-1:0]  w_fix_q, w_fix_r;

    assign w_nabs = abs32(dividend);
    assign w_dabs = abs16(divisor);

    div_step u_step (
        .i_rem  (r_rem),
        .i_bit  (r_nlo[DIVISOR_W-1]),
        .i_div  (r_dabs),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid) w_next = CALC;
            CALC:    if (r_cnt == 5'(ITER - 1)) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    // Negative quotients may reach magnitude 32768; positive ones stop at 32767.
    always_comb begin
        w_s_ovf = r_uovf | (!r_sign_q & r_q[DIVISOR_W-1]) | (r_sign_q & (r_q > 16'h8000));
        w_fix_q = r_sign_q ? (~r_q + 16'd1) : r_q;
        w_fix_r = r_sign_r ? (~r_rem + 16'd1) : r_rem;
        if (r_dz_p) begin
            w_fix_q = Q_DZ;
            w_fix_r = r_nraw_lo;
        end else if (w_s_ovf) begin
            w_fix_q = Q_OVF;
            w_fix_r = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_nlo     <= '0;
            r_q       <= '0;
            r_dabs    <= '0;
            r_nraw_lo <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_dz_p    <= 1'b0;
            r_uovf    <= 1'b0;
            r_quot    <= '0;
            r_rmdr    <= '0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (in_valid) begin
                    r_rem     <= w_nabs[DIVIDEND_W-1:DIVISOR_W];
                    r_nlo     <= w_nabs[DIVISOR_W-1:0];
                    r_dabs    <= w_dabs;
                    r_q       <= '0;
                    r_nraw_lo <= dividend[DIVISOR_W-1:0];
                    r_sign_q  <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                    r_sign_r  <= dividend[DIVIDEND_W-1];
                    r_dz_p    <= (divisor == '0);
                    r_uovf    <= (divisor != '0) && (w_nabs[DIVIDEND_W-1:DIVISOR_W] >= w_dabs);
                    r_cnt     <= '0;
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_q   <= {r_q[DIVISOR_W-2:0], w_qbit};
                    r_nlo <= {r_nlo[DIVISOR_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                end
                FIX: begin
                    r_quot <= w_fix_q;
                    r_rmdr <= w_fix_r;
                    r_dz   <= r_dz_p;
                    r_ovf  <= !r_dz_p & w_s_ovf;
                end
                default: ;
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rmdr;
    assign dz        = r_dz;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_div32by16_signed.sv
// Self-checking bench: directed vector table, handshake/reset corner sequences, random ops vs arithmetic model.
module tb_div32by16_signed;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        in_ready, out_valid, dz, ovf;
    logic [15:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    div32by16_signed dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .ovf       (ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] n;
        logic [15:0] d;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed division with truncation toward zero.
    task automatic ref_div(input logic [31:0] n, input logic [15:0] d,
                           output logic [15:0] q, output logic [15:0] r,
                           output logic edz, output logic eovf);
        longint sn, sd, qq, rr;
        sn = longint'($signed(n));
        sd = longint'($signed(d));
        edz = 1'b0;
        eovf = 1'b0;
        if (sd == 0) begin
            edz = 1'b1;
            q = 16'hFFFF;
            r = n[15:0];
        end else begin
            qq = sn / sd;
            rr = sn % sd;
            if (qq > 32767 || qq < -32768) begin
                eovf = 1'b1;
                q = 16'h8000;
                r = 16'h0000;
            end else begin
                q = qq[15:0];
                r = rr[15:0];
            end
        end
    endtask

    // Issue one op; hold out_ready low for `hold` cycles once the result appears.
    task automatic do_op(input logic [31:0] n, input logic [15:0] d, input int hold,
                         output logic [15:0] q, output logic [15:0] r,
                         output logic odz, output logic oovf, output int lat);
        @(negedge CLK);
        dividend = n;
        divisor = d;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        q = quotient;
        r = remainder;
        odz = dz;
        oovf = ovf;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            @(posedge CLK);
            #1;
            chk("hold_q", quotient, q);
            chk("hold_r", remainder, r);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("handshake_in_ready", in_ready, 1);
        chk("handshake_out_valid", out_valid, 0);
    endtask

    vec_t vecs[12];

    initial begin
        logic [15:0] q, r, eq, er;
        logic        gdz, govf, edz, eovf;
        int          lat;
        bit          leaked;

        vecs[0]  = '{32'd100,      16'd7,      16'd14,    16'd2,     1'b0, 1'b0};
        vecs[1]  = '{32'hFFFFFF9C, 16'd7,      16'hFFF2,  16'hFFFE,  1'b0, 1'b0};
        vecs[2]  = '{32'd100,      16'hFFF9,   16'hFFF2,  16'd2,     1'b0, 1'b0};
        vecs[3]  = '{32'h3FFF0001, 16'h7FFF,   16'h7FFF,  16'h0000,  1'b0, 1'b0};
        vecs[4]  = '{32'hC0008000, 16'h7FFF,   16'h8000,  16'h0000,  1'b0, 1'b0};
        vecs[5]  = '{32'h80000000, 16'hFFFF,   16'h8000,  16'h0000,  1'b0, 1'b1};
        vecs[6]  = '{32'h00010000, 16'h0001,   16'h8000,  16'h0000,  1'b0, 1'b1};
        vecs[7]  = '{32'd12345,    16'h0000,   16'hFFFF,  16'h3039,  1'b1, 1'b0};
        vecs[8]  = '{32'hFFFFFFF9, 16'd2,      16'hFFFD,  16'hFFFF,  1'b0, 1'b0};
        vecs[9]  = '{32'h80000000, 16'h8000,   16'h8000,  16'h0000,  1'b0, 1'b1};
        vecs[10] = '{32'h40000000, 16'h8000,   16'h8000,  16'h0000,  1'b0, 1'b0};
        vecs[11] = '{32'h00008000, 16'h0001,   16'h8000,  16'h0000,  1'b0, 1'b1};

        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dz", dz, 0);
        chk("rst_ovf", ovf, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        foreach (vecs[i]) begin
            do_op(vecs[i].n, vecs[i].d, 0, q, r, gdz, govf, lat);
            chk($sformatf("vec%0d_latency", i), lat, 17);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_r", i), r, vecs[i].r);
            chk($sformatf("vec%0d_dz", i), gdz, vecs[i].dz);
            chk($sformatf("vec%0d_ovf", i), govf, vecs[i].ovf);
        end

        // Consumer stall in DONE; operands toggled while busy must be ignored.
        do_op(32'd100, 16'd7, 5, q, r, gdz, govf, lat);
        chk("stall_latency", lat, 17);
        chk("stall_q", q, 16'd14);
        chk("stall_r", r, 16'd2);

        // Leave nonzero outputs, then reset mid-CALC and confirm nothing escapes.
        do_op(32'd1000, 16'd3, 0, q, r, gdz, govf, lat);
        chk("pre_reset_q", q, 16'd333);
        @(negedge CLK);
        dividend = 32'd5000;
        divisor = 16'd7;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_dz", dz, 0);
        chk("midrst_ovf", ovf, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        leaked = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge CLK);
            #1;
            if (out_valid || !in_ready) leaked = 1'b1;
        end
        chk("midrst_no_result", leaked, 0);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] n;
            logic [15:0] d;
            longint      qv, dv, mag;
            if (i % 3 == 0) begin
                n = $urandom;
                d = (i % 21 == 0) ? 16'h0000 : 16'($urandom);
            end else begin
                d = 16'($urandom);
                if (d == 16'h0000) d = 16'h0001;
                dv = longint'($signed(d));
                mag = (dv < 0) ? -dv : dv;
                qv = longint'($urandom_range(0, 65535)) - 32768;
                qv = qv * dv + ((i % 2 == 0) ? 1 : -1) * longint'($urandom % 32'(mag));
                n = qv[31:0];
            end
            ref_div(n, d, eq, er, edz, eovf);
            do_op(n, d, 0, q, r, gdz, govf, lat);
            chk($sformatf("rnd%0d_latency", i), lat, 17);
            chk($sformatf("rnd%0d_q n=%0h d=%0h", i, n, d), q, eq);
            chk($sformatf("rnd%0d_r n=%0h d=%0h", i, n, d), r, er);
            chk($sformatf("rnd%0d_dz", i), gdz, edz);
            chk($sformatf("rnd%0d_ovf", i), govf, eovf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
